// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer. Owns the program counter, addresses the
//   combinational instruction memory, and keeps fetched words in a 2-entry
//   prefetch queue that feeds decode.
//
//   Handshake: a word moves from fetch to decode on a rising edge where
//   instr_valid and instr_ready are both high and branch_valid is low. While
//   instr_valid is high and instr_ready is low, instr_out and instr_pc hold
//   steady. A branch_valid pulse flushes the queue and discards the current
//   head, even if instr_ready is high in that same cycle.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   mem_pointer    instruction memory address, {zeros, pc}
//   mem_data       combinational instruction memory read data
//   instr_out      instruction at the queue head
//   instr_pc       address of the instruction at the queue head
//   instr_valid    queue head holds a word
//   instr_ready    decode takes the head this cycle
//   branch_valid   redirect pulse from execute
//   branch_target  redirect address
//   halt           level; stops new fetches while high
//   fetch_pc       current pc, the next address to fetch
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [WORD_SIZE-1:0] mem_pointer,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 branch_valid,
    input  logic [ADDR_BITS-1:0] branch_target,
    input  logic                 halt,
    output logic [ADDR_BITS-1:0] fetch_pc
);

    logic [ADDR_BITS-1:0] pc;
    logic [1:0]           count;
    logic [1:0]           count_nxt;
    logic [WORD_SIZE-1:0] tail_data;
    logic [ADDR_BITS-1:0] tail_pc;

    logic pop;
    logic push;
    logic load_head_new;   // head <= freshly fetched word
    logic load_head_tail;  // head <= second entry (queue shifts)
    logic load_tail_new;   // second entry <= freshly fetched word

    assign mem_pointer = {{(WORD_SIZE-ADDR_BITS){1'b0}}, pc};
    assign fetch_pc    = pc;

    always_comb begin
        pop            = instr_valid & instr_ready & ~branch_valid;
        // A full queue can still accept a word when the head leaves in the
        // same cycle, which is what sustains one instruction per cycle.
        push           = ~halt & ~branch_valid & ((count != 2'd2) | pop);
        count_nxt      = count;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail_new  = 1'b0;

        if (branch_valid) begin
            count_nxt = 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        load_head_new = 1'b1;
                        count_nxt     = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        load_tail_new = 1'b1;
                        count_nxt     = 2'd2;
                    end else if (pop) begin
                        count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    // push implies pop here, so only the pop cases matter.
                    if (pop) begin
                        load_head_tail = 1'b1;
                        if (push) begin
                            load_tail_new = 1'b1;
                        end else begin
                            count_nxt = 2'd1;
                        end
                    end
                end
                default: count_nxt = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            count       <= 2'd0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            tail_data   <= '0;
            tail_pc     <= '0;
        end else begin
            count       <= count_nxt;
            instr_valid <= (count_nxt != 2'd0);

            if (branch_valid) begin
                pc <= branch_target;
            end else if (push) begin
                pc <= pc + {{(ADDR_BITS-1){1'b0}}, 1'b1};
            end

            if (load_head_new) begin
                instr_out <= mem_data;
                instr_pc  <= pc;
            end else if (load_head_tail) begin
                instr_out <= tail_data;
                instr_pc  <= tail_pc;
            end

            if (load_tail_new) begin
                tail_data <= mem_data;
                tail_pc   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_pointer;
    logic [15:0] mem_data;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        halt;
    logic [7:0]  fetch_pc;

    logic [15:0] imem [256];

    int tests = 0;
    int fails = 0;

    // Scoreboard: program-order stream of {pc, word} that decode should see.
    logic [23:0] exp_q[$];
    logic [7:0]  fill_pc;

    fetch_unit #(.WORD_SIZE(16), .ADDR_BITS(8), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_pointer   (mem_pointer),
        .mem_data      (mem_data),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .fetch_pc      (fetch_pc)
    );

    // clock / memory
    always #5 clk = ~clk;

    always_comb mem_data = imem[mem_pointer[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({fill_pc, imem[fill_pc]});
            fill_pc = fill_pc + 8'd1;
        end
    endtask

    task automatic sb_restart(input logic [7:0] start);
        exp_q.delete();
        fill_pc = start;
        sb_refill();
    endtask

    // Monitor: every accepted word must be the next one in program order.
    always @(negedge clk) begin
        logic [23:0] e;
        if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1 &&
            branch_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got pc %0h with no expected word", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e[23:16]);
                chk("sb_data", instr_out, e[15:0]);
                sb_refill();
            end
        end
    end

    // driver: apply one cycle of inputs, return 1 time unit after the edge
    task automatic step(input logic rst, input logic rdy, input logic hlt,
                        input logic br, input logic [7:0] tgt);
        reset         = rst;
        instr_ready   = rdy;
        halt          = hlt;
        branch_valid  = br;
        branch_target = tgt;
        if (rst) sb_restart(8'h00);
        else if (br) sb_restart(tgt);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_v;
        logic [7:0]  exp_ipc;
        logic [15:0] exp_iout;
        logic [7:0]  exp_fpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic v,
                       input logic [7:0] ipc, input logic [15:0] iout, input logic [7:0] fpc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.exp_v = v;
        r.exp_ipc = ipc; r.exp_iout = iout; r.exp_fpc = fpc;
        vecs.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h5000 + 16'(i);
        imem[8'h00] = 16'h0000;
        imem[8'h01] = 16'hE300;
        imem[8'h02] = 16'hF380;
        imem[8'h0B] = 16'hB001;
        imem[8'h0C] = 16'hB201;

        // basic flow after reset, ready held high
        add(0, 1, 1, 8'h00, 16'h0000, 8'h01);
        add(0, 1, 1, 8'h01, 16'hE300, 8'h02);
        add(0, 1, 1, 8'h02, 16'hF380, 8'h03);
        // back-pressure: reset, then ready low for 6 cycles, then ready high
        add(1, 0, 0, 8'h00, 16'h0000, 8'h00);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h01);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h02);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h02);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h02);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h02);
        add(0, 0, 1, 8'h00, 16'h0000, 8'h02);
        add(0, 1, 1, 8'h01, 16'hE300, 8'h03);
        add(0, 1, 1, 8'h02, 16'hF380, 8'h04);
        add(0, 1, 1, 8'h03, 16'h5003, 8'h05);

        // reset state
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_out", instr_out, 16'h0000);
        chk("rst_ipc", instr_pc, 8'h00);
        chk("rst_fpc", fetch_pc, 8'h00);
        chk("rst_ptr", mem_pointer, 16'h0000);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].rdy, 0, 0, 8'h00);
            chk($sformatf("vec%0d_valid", k), instr_valid, vecs[k].exp_v);
            chk($sformatf("vec%0d_fpc", k), fetch_pc, vecs[k].exp_fpc);
            if (vecs[k].exp_v || vecs[k].rst) begin
                chk($sformatf("vec%0d_ipc", k), instr_pc, vecs[k].exp_ipc);
                chk($sformatf("vec%0d_out", k), instr_out, vecs[k].exp_iout);
            end
        end

        // redirect in steady flow to 0x0B
        step(0, 1, 0, 1, 8'h0B);
        chk("br_bubble_valid", instr_valid, 1'b0);
        chk("br_fpc", fetch_pc, 8'h0B);
        chk("br_ptr", mem_pointer, 16'h000B);
        step(0, 1, 0, 0, 8'h00);
        chk("br_first_valid", instr_valid, 1'b1);
        chk("br_first_ipc", instr_pc, 8'h0B);
        chk("br_first_out", instr_out, 16'hB001);
        step(0, 1, 0, 0, 8'h00);
        chk("br_second_ipc", instr_pc, 8'h0C);
        chk("br_second_out", instr_out, 16'hB201);

        // redirect to top of address space, pc wraps
        step(0, 1, 0, 1, 8'hFF);
        chk("wrap_fpc", fetch_pc, 8'hFF);
        step(0, 1, 0, 0, 8'h00);
        chk("wrap_ipc_ff", instr_pc, 8'hFF);
        chk("wrap_fpc0", fetch_pc, 8'h00);
        chk("wrap_ptr", mem_pointer, 16'h0000);
        step(0, 1, 0, 0, 8'h00);
        chk("wrap_ipc_00", instr_pc, 8'h00);
        chk("wrap_out_00", instr_out, 16'h0000);

        // halt with a full queue: two words drain, then nothing until release
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("full_fpc", fetch_pc, 8'h02);
        step(0, 1, 1, 0, 8'h00);
        chk("halt_drain1_valid", instr_valid, 1'b1);
        chk("halt_drain1_ipc", instr_pc, 8'h01);
        step(0, 1, 1, 0, 8'h00);
        chk("halt_empty_valid", instr_valid, 1'b0);
        step(0, 1, 1, 0, 8'h00);
        chk("halt_empty2_valid", instr_valid, 1'b0);
        chk("halt_fpc_frozen", fetch_pc, 8'h02);
        step(0, 1, 0, 0, 8'h00);
        chk("halt_resume_valid", instr_valid, 1'b1);
        chk("halt_resume_ipc", instr_pc, 8'h02);
        chk("halt_resume_out", instr_out, 16'hF380);

        // reset beats a concurrent branch with a full queue
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 1, 8'h40);
        chk("rst_br_valid", instr_valid, 1'b0);
        chk("rst_br_fpc", fetch_pc, 8'h00);
        chk("rst_br_ptr", mem_pointer, 16'h0000);
        step(0, 1, 0, 0, 8'h00);
        chk("rst_br_restart_ipc", instr_pc, 8'h00);
        chk("rst_br_restart_out", instr_out, 16'h0000);
        step(0, 1, 0, 0, 8'h00);
        chk("rst_br_next_out", instr_out, 16'hE300);

        // random traffic, checked by the scoreboard only
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0,
                 8'($urandom_range(0, 255)));
        end
        for (int n = 0; n < 8; n++) step(0, 1, 0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
